l2_command_issuer: RTL and testbench

- Transmit-side front end for the L2 cache command/address interface.
- Accepts trace-style command/address pairs from a producer (trace parser or bus model) and buffers them in a FIFO.
- Presents them to the cache one at a time over a valid/ready handshake.
- Drops illegal command codes, orders clear (8) and print (9) behind in-flight cache activity, and keeps per-class issue statistics.

---
 rtl/l2_command_issuer.sv | 207 ++++++++++++++++++++
 tb/tb_l2_command_issuer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_command_issuer.sv
`default_nettype none
// ============================================================================
// l2_command_issuer : buffers trace command/address pairs and issues them to
// the L2 cache one at a time, fencing clear/print behind cache activity.
// Revision: 1.0
// ============================================================================
module l2_command_issuer #(
  parameter int COMMAND_SIZE = 8,
  parameter int ADDRESS_SIZE = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COMMAND_SIZE-1:0]       in_command,
  input  logic [ADDRESS_SIZE-1:0]       in_address,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COMMAND_SIZE-1:0]       out_command,
  output logic [ADDRESS_SIZE-1:0]       out_address,
  input  logic                          cache_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [COUNT_WIDTH-1:0]        read_count,
  output logic [COUNT_WIDTH-1:0]        write_count,
  output logic [COUNT_WIDTH-1:0]        snoop_count,
  output logic [COUNT_WIDTH-1:0]        drop_count
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]       c_FULL    = (c_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [c_PTR_W:0]       c_LVL_ONE = (c_PTR_W+1)'(1);
  localparam logic [c_PTR_W-1:0]     c_PTR_ONE = c_PTR_W'(1);
  localparam logic [COMMAND_SIZE-1:0] c_CMD_READ   = COMMAND_SIZE'(0);
  localparam logic [COMMAND_SIZE-1:0] c_CMD_WRITE  = COMMAND_SIZE'(1);
  localparam logic [COMMAND_SIZE-1:0] c_CMD_IFETCH = COMMAND_SIZE'(2);
  localparam logic [COMMAND_SIZE-1:0] c_CMD_SNP_LO = COMMAND_SIZE'(3);
  localparam logic [COMMAND_SIZE-1:0] c_CMD_SNP_HI = COMMAND_SIZE'(6);
  localparam logic [COMMAND_SIZE-1:0] c_CMD_CLEAR  = COMMAND_SIZE'(8);
  localparam logic [COMMAND_SIZE-1:0] c_CMD_PRINT  = COMMAND_SIZE'(9);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_BARRIER = 2'd1,
    S_ISSUE   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [COMMAND_SIZE-1:0] mem_cmd_q  [FIFO_DEPTH];
  logic [ADDRESS_SIZE-1:0] mem_addr_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [c_PTR_W:0]        level_q;

  logic                    out_valid_q, out_valid_d;
  logic [COMMAND_SIZE-1:0] out_cmd_q, out_cmd_d;
  logic [ADDRESS_SIZE-1:0] out_addr_q, out_addr_d;

  logic [COUNT_WIDTH-1:0]  read_q, read_d, write_q, write_d;
  logic [COUNT_WIDTH-1:0]  snoop_q, snoop_d, drop_q, drop_d;

  logic w_full, w_empty, w_legal, w_in_hs, w_push, w_drop, w_out_hs;
  logic w_head_barrier;
  logic [COMMAND_SIZE-1:0] w_head_cmd;
  logic [ADDRESS_SIZE-1:0] w_head_addr;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign w_full         = (level_q == c_FULL);
  assign w_empty        = (level_q == '0);
  assign w_legal        = (in_command <= c_CMD_SNP_HI) || (in_command == c_CMD_CLEAR) ||
                          (in_command == c_CMD_PRINT);
  assign w_in_hs        = in_valid && !w_full;
  assign w_push         = w_in_hs && w_legal;
  assign w_drop         = w_in_hs && !w_legal;
  // out_valid is only ever high in ISSUE, so the output handshake is the pop.
  assign w_out_hs       = out_valid_q && out_ready;
  assign w_head_cmd     = mem_cmd_q[rd_ptr_q];
  assign w_head_addr    = mem_addr_q[rd_ptr_q];
  assign w_head_barrier = (w_head_cmd == c_CMD_CLEAR) || (w_head_cmd == c_CMD_PRINT);

  always_ff @(posedge clk) begin
    if (w_push) begin
      mem_cmd_q[wr_ptr_q]  <= in_command;
      mem_addr_q[wr_ptr_q] <= in_address;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (w_push)   wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
      if (w_out_hs) rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      case ({w_push, w_out_hs})
        2'b10:   level_q <= level_q + c_LVL_ONE;
        2'b01:   level_q <= level_q - c_LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_cmd_d   = out_cmd_q;
    out_addr_d  = out_addr_q;
    case (state_q)
      S_IDLE: begin
        if (!w_empty) begin
          if (w_head_barrier) begin
            state_d = S_BARRIER;
          end else begin
            state_d     = S_ISSUE;
            out_valid_d = 1'b1;
            out_cmd_d   = w_head_cmd;
            out_addr_d  = w_head_addr;
          end
        end
      end
      S_BARRIER: begin
        if (!cache_busy) begin
          state_d     = S_ISSUE;
          out_valid_d = 1'b1;
          out_cmd_d   = w_head_cmd;
          out_addr_d  = w_head_addr;
        end
      end
      S_ISSUE: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_addr_q  <= out_addr_d;
    end
  end

  // A clear issued on the same edge as a drop wins; the clear itself is uncounted.
  always_comb begin
    read_d  = read_q;
    write_d = write_q;
    snoop_d = snoop_q;
    drop_d  = drop_q;
    if (w_out_hs && (out_cmd_q == c_CMD_CLEAR)) begin
      read_d  = '0;
      write_d = '0;
      snoop_d = '0;
      drop_d  = '0;
    end else begin
      if (w_out_hs) begin
        if ((out_cmd_q == c_CMD_READ) || (out_cmd_q == c_CMD_IFETCH)) read_d = sat_inc(read_q);
        if (out_cmd_q == c_CMD_WRITE) write_d = sat_inc(write_q);
        if ((out_cmd_q >= c_CMD_SNP_LO) && (out_cmd_q <= c_CMD_SNP_HI)) snoop_d = sat_inc(snoop_q);
      end
      if (w_drop) drop_d = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_q  <= '0;
      write_q <= '0;
      snoop_q <= '0;
      drop_q  <= '0;
    end else begin
      read_q  <= read_d;
      write_q <= write_d;
      snoop_q <= snoop_d;
      drop_q  <= drop_d;
    end
  end

  assign in_ready    = !w_full;
  assign out_valid   = out_valid_q;
  assign out_command = out_cmd_q;
  assign out_address = out_addr_q;
  assign fifo_level  = level_q;
  assign read_count  = read_q;
  assign write_count = write_q;
  assign snoop_count = snoop_q;
  assign drop_count  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_l2_command_issuer.sv
`default_nettype none
// ============================================================================
// tb_l2_command_issuer : scoreboard bench with random traffic and a
// queue-based reference model of the issuer.
// Revision: 1.0
// ============================================================================
module tb_l2_command_issuer;
  localparam int DEPTH = 4;
  localparam int CMAX  = 65535;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, cache_busy;
  logic [7:0]  in_command;
  logic [31:0] in_address;
  logic        in_ready, out_valid;
  logic [7:0]  out_command;
  logic [31:0] out_address;
  logic [2:0]  fifo_level;
  logic [15:0] read_count, write_count, snoop_count, drop_count;

  always #5 clk = ~clk;

  l2_command_issuer #(.COMMAND_SIZE(8), .ADDRESS_SIZE(32), .FIFO_DEPTH(DEPTH), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_command(in_command), .in_address(in_address), .out_valid(out_valid),
    .out_ready(out_ready), .out_command(out_command), .out_address(out_address),
    .cache_busy(cache_busy), .fifo_level(fifo_level), .read_count(read_count),
    .write_count(write_count), .snoop_count(snoop_count), .drop_count(drop_count)
  );

  typedef struct packed { logic [7:0] c; logic [31:0] a; } item_t;
  item_t exp_q[$];

  int n_cmp = 0, n_err = 0;
  int m_read = 0, m_write = 0, m_snoop = 0, m_drop = 0, m_level = 0;
  int rdy_mode = 0;
  bit busy_rand = 1'b0;
  logic        prev_ov, prev_or, prev_busy;
  logic [7:0]  prev_cmd;
  logic [31:0] prev_addr;

  function automatic bit legal(input logic [7:0] c);
    return (c <= 8'd6) || (c == 8'd8) || (c == 8'd9);
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] c, input logic [31:0] a);
    int w = 0;
    in_valid = 1'b1; in_command = c; in_address = a;
    while (!in_ready && w < 300) begin tick(1); w++; end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: in_ready stuck 0 for cmd 0x%0h, required 1", c);
      in_valid = 1'b0;
      return;
    end
    if (legal(c)) exp_q.push_back({c, a});
    tick(1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin tick(1); w++; end
    check("drain_queue_empty", exp_q.size(), 0);
    tick(3);
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_read = 0; m_write = 0; m_snoop = 0; m_drop = 0; m_level = 0;
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (busy_rand) cache_busy = ($urandom_range(0, 3) == 0);
  end

  // Monitor: compare state reached at the last edge, then fold in the
  // handshakes that the coming edge will perform.
  always @(negedge clk) begin
    item_t e;
    if (!rst_n) begin
      prev_ov = 1'b0; prev_or = 1'b0; prev_busy = 1'b0;
    end else begin
      check("read_count",  read_count,  m_read);
      check("write_count", write_count, m_write);
      check("snoop_count", snoop_count, m_snoop);
      check("drop_count",  drop_count,  m_drop);
      check("fifo_level",  fifo_level,  m_level);
      check("in_ready",    in_ready,    (m_level != DEPTH));
      if (prev_ov && !prev_or) begin
        check("hold_valid", out_valid,   1);
        check("hold_cmd",   out_command, prev_cmd);
        check("hold_addr",  out_address, prev_addr);
      end
      if (out_valid && !prev_ov && (out_command == 8'd8 || out_command == 8'd9))
        check("barrier_busy", prev_busy, 0);
      if (in_valid && in_ready) begin
        if (legal(in_command)) m_level++;
        else m_drop = sat(m_drop);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_issue: got cmd 0x%0h, required no issue", out_command);
        end else begin
          e = exp_q.pop_front();
          check("issue_cmd",  out_command, e.c);
          check("issue_addr", out_address, e.a);
          case (e.c)
            8'd0, 8'd2:             m_read  = sat(m_read);
            8'd1:                   m_write = sat(m_write);
            8'd3, 8'd4, 8'd5, 8'd6: m_snoop = sat(m_snoop);
            8'd8: begin m_read = 0; m_write = 0; m_snoop = 0; m_drop = 0; end
            default: ;
          endcase
          m_level--;
        end
      end
      prev_ov = out_valid; prev_or = out_ready; prev_busy = cache_busy;
      prev_cmd = out_command; prev_addr = out_address;
    end
  end

  initial begin
    logic [7:0] c;
    int r;
    rst_n = 1'b0; in_valid = 1'b0; in_command = '0; in_address = '0;
    cache_busy = 1'b0; out_ready = 1'b0;
    tick(2);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_cmd",   out_command, 0);
    check("rst_out_addr",  out_address, 0);
    check("rst_in_ready",  in_ready, 1);
    check("rst_level",     fifo_level, 0);
    check("rst_counters",  {read_count, write_count, snoop_count, drop_count}, 0);
    rst_n = 1'b1;
    tick(1);

    // Basic latency: push at edge N, presented after edge N+1.
    rdy_mode = 1;
    send(8'd0, 32'h0000_1000);
    check("t1_not_yet_valid", out_valid, 0);
    tick(1);
    check("t1_valid",   out_valid, 1);
    check("t1_cmd",     out_command, 8'd0);
    check("t1_addr",    out_address, 32'h0000_1000);
    tick(3);
    check("t1_read_count", read_count, 1);
    check("t1_level",      fifo_level, 0);

    // Fill the FIFO with the cache stalled.
    rdy_mode = 0;
    tick(1);
    send(8'd1, 32'h100); send(8'd2, 32'h104); send(8'd3, 32'h108); send(8'd4, 32'h10C);
    check("t2_full_ready", in_ready, 0);
    check("t2_full_level", fifo_level, 4);
    in_valid = 1'b1; in_command = 8'd5; in_address = 32'h110;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t2_held_ready", in_ready, 0);
      check("t2_stable_cmd", out_command, 8'd1);
      check("t2_stable_addr", out_address, 32'h100);
    end
    rdy_mode = 1;
    send(8'd5, 32'h110);
    drain();

    // Illegal codes are swallowed without disturbing order.
    send(8'd7, 32'h0); send(8'd1, 32'hDEAD_BEEC); send(8'h0A, 32'h0); send(8'hFF, 32'h0);
    drain();
    check("t3_drop_count",  drop_count, 3);
    check("t3_write_count", write_count, 2);

    // Clear waits for the cache to go idle, then zeroes the statistics.
    cache_busy = 1'b1;
    send(8'd8, 32'h0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("t4_barrier_hold", out_valid, 0);
    end
    cache_busy = 1'b0;
    tick(1);
    check("t4_valid", out_valid, 1);
    check("t4_cmd",   out_command, 8'd8);
    tick(2);
    check("t4_cleared", {read_count, write_count, snoop_count, drop_count}, 0);

    // Snoops and a print under random backpressure.
    rdy_mode = 2;
    cache_busy = 1'b1;
    send(8'd3, 32'h200); send(8'd4, 32'h204); send(8'd5, 32'h208);
    send(8'd6, 32'h20C); send(8'd2, 32'h210); send(8'd9, 32'h214);
    tick(100);
    check("t5_print_waiting", exp_q.size(), 1);
    check("t5_print_not_issued", out_valid, 0);
    cache_busy = 1'b0;
    drain();
    check("t5_snoop_count", snoop_count, 4);
    check("t5_read_count",  read_count, 1);

    // Reset while a command is presented with entries queued.
    rdy_mode = 0;
    send(8'd0, 32'h300); send(8'd1, 32'h304); send(8'd2, 32'h308);
    tick(2);
    check("t6_presented", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid",    out_valid, 0);
    check("t6_rst_level",    fifo_level, 0);
    check("t6_rst_counters", {read_count, write_count, snoop_count, drop_count}, 0);
    clear_model();
    tick(2);
    rst_n = 1'b1;
    rdy_mode = 1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t6_no_issue", out_valid, 0);
    end

    // Random traffic.
    rdy_mode = 2;
    busy_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       c = 8'($urandom_range(0, 6));
      else if (r == 7) c = 8'($urandom_range(8, 9));
      else             c = 8'($urandom_range(7, 255));
      send(c, $urandom);
      tick($urandom_range(0, 2));
    end
    busy_rand = 1'b0;
    cache_busy = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
